// File: rtl/cmsdk_mcu_ahb_resp_mux.sv
// AHB data-phase response mux with built-in default slave (two-cycle ERROR for unmapped
// active transfers). Optional multi-hot select checking enabled by AHB_MUX_ONEHOT_CHECK_EN.
module cmsdk_mcu_ahb_resp_mux #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned DW         = 32
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [NUM_SLAVES-1:0]    hsel_in,
    input  logic [1:0]               htrans,
    input  logic                     hready,
    input  logic [NUM_SLAVES-1:0]    hreadyout_s,
    input  logic [NUM_SLAVES-1:0]    hresp_s,
    input  logic [NUM_SLAVES*DW-1:0] hrdata_s,
    output logic                     hreadyout,
    output logic                     hresp,
    output logic [DW-1:0]            hrdata,
    output logic                     multi_sel_err
);

    typedef enum logic [1:0] {
        DsIdle = 2'd0,
        DsErr1 = 2'd1,
        DsErr2 = 2'd2
    } ds_state_e;

    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    ds_state_e             ds_q, ds_d;
    logic                  unmapped;
    logic                  err_start;
    logic                  ds_ready;
    logic                  ds_resp;

`ifdef AHB_MUX_ONEHOT_CHECK_EN
    logic multi_hot;
    logic multi_sel_err_q, multi_sel_err_d;

    // x & (x-1) clears the lowest set bit; anything left means more than one bit was set.
    assign multi_hot = |(hsel_in & (hsel_in - NUM_SLAVES'(1)));
    assign unmapped  = (hsel_in == '0) | multi_hot;

    always_comb begin
        multi_sel_err_d = multi_sel_err_q;
        if (hready && multi_hot) begin
            multi_sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            multi_sel_err_q <= 1'b0;
        end else begin
            multi_sel_err_q <= multi_sel_err_d;
        end
    end

    assign multi_sel_err = multi_sel_err_q;
`else
    assign unmapped      = (hsel_in == '0);
    assign multi_sel_err = 1'b0;
`endif

    // Only NONSEQ/SEQ to an unmapped address earns an ERROR; IDLE/BUSY get a zero-wait OKAY.
    assign err_start = hready & htrans[1] & unmapped;

    always_comb begin
        sel_d = sel_q;
        if (hready) begin
            sel_d = unmapped ? '0 : hsel_in;
        end
    end

    always_comb begin
        ds_d     = ds_q;
        ds_ready = 1'b1;
        ds_resp  = 1'b0;
        unique case (ds_q)
            DsIdle: begin
                if (err_start) begin
                    ds_d = DsErr1;
                end
            end
            DsErr1: begin
                ds_ready = 1'b0;
                ds_resp  = 1'b1;
                ds_d     = DsErr2;
            end
            DsErr2: begin
                ds_resp = 1'b1;
                ds_d    = err_start ? DsErr1 : DsIdle;
            end
            default: begin
                ds_d = DsIdle;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            sel_q <= '0;
            ds_q  <= DsIdle;
        end else begin
            sel_q <= sel_d;
            ds_q  <= ds_d;
        end
    end

    // Lowest set index wins, so a multi-hot sel_q still resolves to a single slave.
    always_comb begin
        logic found;
        found     = 1'b0;
        hreadyout = ds_ready;
        hresp     = ds_resp;
        hrdata    = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i] && !found) begin
                found     = 1'b1;
                hreadyout = hreadyout_s[i];
                hresp     = hresp_s[i];
                hrdata    = hrdata_s[i*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_mcu_ahb_resp_mux.sv
// Self-checking bench for cmsdk_mcu_ahb_resp_mux: directed cases plus random traffic
// compared every cycle against a transfer-level model of the response mux.
module tb_cmsdk_mcu_ahb_resp_mux;

    localparam int unsigned NS = 8;
    localparam int unsigned DW = 32;

`ifdef AHB_MUX_ONEHOT_CHECK_EN
    localparam bit OneHotChk = 1'b1;
`else
    localparam bit OneHotChk = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              hreset;
    logic [NS-1:0]     hsel_in;
    logic [1:0]        htrans;
    logic              hready;
    logic [NS-1:0]     hreadyout_s;
    logic [NS-1:0]     hresp_s;
    logic [NS*DW-1:0]  hrdata_s;
    logic              hreadyout;
    logic              hresp;
    logic [DW-1:0]     hrdata;
    logic              multi_sel_err;

    always #5 clk = ~clk;

    // The mux's own hreadyout is the bus HREADY.
    assign hready = hreadyout;

    cmsdk_mcu_ahb_resp_mux #(
        .NUM_SLAVES (NS),
        .DW         (DW)
    ) dut (
        .hclk          (clk),
        .hreset        (hreset),
        .hsel_in       (hsel_in),
        .htrans        (htrans),
        .hready        (hready),
        .hreadyout_s   (hreadyout_s),
        .hresp_s       (hresp_s),
        .hrdata_s      (hrdata_s),
        .hreadyout     (hreadyout),
        .hresp         (hresp),
        .hrdata        (hrdata),
        .multi_sel_err (multi_sel_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: who owns the data phase (-1 = default slave) and how many ERROR cycles remain.
    int            m_owner = -1;
    int            m_err   = 0;
    bit            m_flag  = 1'b0;
    logic [NS-1:0] p_hsel    = '0;
    logic [1:0]    p_htrans  = '0;
    logic          p_hready  = 1'b1;
    bit            cmp_en    = 1'b0;

    always @(posedge clk or posedge hreset) begin
        int cnt;
        int low;
        if (hreset) begin
            m_owner = -1;
            m_err   = 0;
            m_flag  = 1'b0;
        end else if (m_err == 2) begin
            m_err = 1;
        end else if (p_hready) begin
            cnt = 0;
            low = -1;
            for (int i = 0; i < NS; i++) begin
                if (p_hsel[i]) begin
                    cnt++;
                    if (low < 0) low = i;
                end
            end
            if (cnt == 0 || (OneHotChk && cnt > 1)) begin
                m_owner = -1;
                m_err   = p_htrans[1] ? 2 : 0;
                if (cnt > 1) m_flag = 1'b1;
            end else begin
                m_owner = low;
                m_err   = 0;
            end
        end else if (m_err == 1) begin
            m_err = 0;
        end
    end

    always @(negedge clk) begin
        logic          e_ready;
        logic          e_resp;
        logic [DW-1:0] e_data;
        p_hsel   = hsel_in;
        p_htrans = htrans;
        p_hready = hready;
        if (cmp_en) begin
            if (m_owner >= 0) begin
                e_ready = hreadyout_s[m_owner];
                e_resp  = hresp_s[m_owner];
                e_data  = hrdata_s[m_owner*DW +: DW];
            end else begin
                e_ready = (m_err != 2);
                e_resp  = (m_err != 0);
                e_data  = '0;
            end
            chk("model_hreadyout", 32'(hreadyout), 32'(e_ready));
            chk("model_hresp", 32'(hresp), 32'(e_resp));
            chk("model_hrdata", hrdata, e_data);
            chk("model_multi_sel_err", 32'(multi_sel_err), 32'(m_flag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hsel_in = '0;
        htrans  = 2'b00;
    endtask

    initial begin
        logic [NS-1:0] rs;
        hreset      = 1'b1;
        set_idle();
        hreadyout_s = '1;
        hresp_s     = '0;
        hrdata_s    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state
        chk("t1_hreadyout", 32'(hreadyout), 32'd1);
        chk("t1_hresp", 32'(hresp), 32'd0);
        chk("t1_hrdata", hrdata, 32'd0);
        chk("t1_multi_sel_err", 32'(multi_sel_err), 32'd0);
        cmp_en = 1'b1;
        step();
        hreset = 1'b0;
        step();

        // Mapped read to slave 2 with one wait state
        hsel_in = 8'h04;
        htrans  = 2'b10;
        step();
        set_idle();
        hrdata_s[2*DW +: DW] = 32'hDEADBEEF;
        hreadyout_s[2]       = 1'b0;
        @(negedge clk);
        chk("t2_wait_hreadyout", 32'(hreadyout), 32'd0);
        step();
        hreadyout_s[2] = 1'b1;
        @(negedge clk);
        chk("t2_hreadyout", 32'(hreadyout), 32'd1);
        chk("t2_hrdata", hrdata, 32'hDEADBEEF);
        step();

        // Unmapped NONSEQ: two-cycle ERROR then OKAY
        htrans = 2'b10;
        step();
        set_idle();
        @(negedge clk);
        chk("t3_c1_hreadyout", 32'(hreadyout), 32'd0);
        chk("t3_c1_hresp", 32'(hresp), 32'd1);
        step();
        @(negedge clk);
        chk("t3_c2_hreadyout", 32'(hreadyout), 32'd1);
        chk("t3_c2_hresp", 32'(hresp), 32'd1);
        step();
        @(negedge clk);
        chk("t3_c3_hresp", 32'(hresp), 32'd0);

        // Unmapped IDLE: always zero-wait OKAY
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("t4_hreadyout", 32'(hreadyout), 32'd1);
            chk("t4_hresp", 32'(hresp), 32'd0);
        end

        // Pipelined slave1 -> unmapped -> slave3
        step();
        hrdata_s[1*DW +: DW] = 32'h1111_AAAA;
        hrdata_s[3*DW +: DW] = 32'h3333_CCCC;
        hsel_in = 8'h02;
        htrans  = 2'b10;
        step();
        hsel_in = 8'h00;
        @(negedge clk);
        chk("t5_s1_hrdata", hrdata, 32'h1111_AAAA);
        chk("t5_s1_hreadyout", 32'(hreadyout), 32'd1);
        step();
        hsel_in = 8'h08;
        @(negedge clk);
        chk("t5_err1_hreadyout", 32'(hreadyout), 32'd0);
        chk("t5_err1_hresp", 32'(hresp), 32'd1);
        step();
        @(negedge clk);
        chk("t5_err2_hreadyout", 32'(hreadyout), 32'd1);
        chk("t5_err2_hresp", 32'(hresp), 32'd1);
        step();
        set_idle();
        @(negedge clk);
        chk("t5_s3_hrdata", hrdata, 32'h3333_CCCC);
        chk("t5_s3_hresp", 32'(hresp), 32'd0);

        // Multi-hot select 8'h05
        step();
        hrdata_s[0 +: DW] = 32'h0000_5A5A;
        hsel_in = 8'h05;
        htrans  = 2'b10;
        step();
        set_idle();
        @(negedge clk);
        if (OneHotChk) begin
            chk("t6_err1_hreadyout", 32'(hreadyout), 32'd0);
            chk("t6_err1_hresp", 32'(hresp), 32'd1);
            chk("t6_flag", 32'(multi_sel_err), 32'd1);
        end else begin
            chk("t6_s0_hrdata", hrdata, 32'h0000_5A5A);
            chk("t6_s0_hresp", 32'(hresp), 32'd0);
            chk("t6_flag", 32'(multi_sel_err), 32'd0);
        end
        repeat (3) step();
        @(negedge clk);
        chk("t6_flag_sticky", 32'(multi_sel_err), OneHotChk ? 32'd1 : 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step();
            if (hreset) begin
                hreset = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                hreset = 1'b1;
            end
            case ($urandom_range(0, 9))
                0, 1, 2:          hsel_in = '0;
                3, 4, 5, 6, 7:    hsel_in = NS'(1) << $urandom_range(0, NS - 1);
                default:          hsel_in = NS'($urandom);
            endcase
            htrans = 2'($urandom);
            for (int i = 0; i < NS; i++) begin
                rs[i] = ($urandom_range(0, 3) != 0);
            end
            hreadyout_s = rs;
            for (int i = 0; i < NS; i++) begin
                rs[i] = ($urandom_range(0, 9) == 0);
            end
            hresp_s  = rs;
            hrdata_s = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
        end

        // Reset asserted while the default slave sits in its first ERROR cycle
        step();
        hreset      = 1'b0;
        set_idle();
        hreadyout_s = '1;
        repeat (3) step();
        htrans = 2'b10;
        step();
        set_idle();
        hreset = 1'b1;
        #1;
        chk("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_mid_hresp", 32'(hresp), 32'd0);
        chk("rst_mid_flag", 32'(multi_sel_err), 32'd0);
        step();
        hreset = 1'b0;
        repeat (2) step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
